dmux_stream: RTL and testbench

DMUX_STREAM -- requirements
Module: dmux_stream

---
 rtl/dmux_stream.sv | 106 ++++++++++
 tb/tb_dmux_stream.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/dmux_stream.sv
// dmux_stream: one-to-NWAY stream demultiplexer with per-channel one-entry
// output registers and an accepted-transfer counter.
//
// Routes each accepted input word either to a single channel (unicast,
// channel in_sel) or to every channel at once (broadcast). Each channel
// holds one word until its consumer takes it. A channel may drain and
// refill on the same edge, so one channel sustains one word per cycle.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-high reset
//   in_data    in   [WIDTH-1:0] word to route
//   in_sel     in   [SEL_W-1:0] destination channel for unicast
//   in_bcast   in   1: broadcast to all channels, 0: unicast to in_sel
//   in_valid   in   upstream offers a word
//   in_ready   out  word accepted this cycle (combinational)
//   out_data   out  [NWAY*WIDTH-1:0] channel k word at [k*WIDTH +: WIDTH]
//   out_valid  out  [NWAY-1:0] channel k holds a word
//   out_ready  in   [NWAY-1:0] channel k consumer takes its word
//   xfer_cnt   out  [15:0] accepted input transfers, wraps at 16'hFFFF
module dmux_stream #(
    parameter int WIDTH = 16,
    parameter int SEL_W = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [WIDTH-1:0]            in_data,
    input  logic [SEL_W-1:0]            in_sel,
    input  logic                        in_bcast,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [(2**SEL_W)*WIDTH-1:0] out_data,
    output logic [(2**SEL_W)-1:0]       out_valid,
    input  logic [(2**SEL_W)-1:0]       out_ready,
    output logic [15:0]                 xfer_cnt
);

    localparam int NWAY = 2**SEL_W;

    logic [NWAY*WIDTH-1:0] data_r;
    logic [NWAY-1:0]       valid_r;
    logic [15:0]           cnt_r;

    logic [NWAY-1:0]       free_s;
    logic [NWAY-1:0]       load_s;
    logic                  ready_s;
    logic                  accept_s;

    // A channel is free when empty, or when its word leaves on this edge.
    assign free_s   = ~valid_r | out_ready;
    assign accept_s = in_valid & ready_s;

    // Input readiness: unicast needs only the target channel, broadcast needs all.
    always_comb begin
        ready_s = 1'b0;
        if (in_bcast) begin
            ready_s = &free_s;
        end else begin
            ready_s = free_s[in_sel];
        end
    end

    // Per-channel load enables for the accepted word.
    always_comb begin
        load_s = '0;
        for (int k = 0; k < NWAY; k++) begin
            if (accept_s && (in_bcast || (in_sel == SEL_W'(k)))) begin
                load_s[k] = 1'b1;
            end else begin
                load_s[k] = 1'b0;
            end
        end
    end

    // Channel registers: load wins over drain so refill keeps the flag set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_r  <= '0;
            valid_r <= '0;
        end else begin
            for (int k = 0; k < NWAY; k++) begin
                if (load_s[k]) begin
                    data_r[k*WIDTH +: WIDTH] <= in_data;
                    valid_r[k]               <= 1'b1;
                end else if (valid_r[k] && out_ready[k]) begin
                    valid_r[k] <= 1'b0;
                end
            end
        end
    end

    // Transfer counter: a broadcast counts once; wraps naturally at 16 bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= 16'd0;
        end else if (accept_s) begin
            cnt_r <= cnt_r + 16'd1;
        end
    end

    assign in_ready  = ready_s;
    assign out_data  = data_r;
    assign out_valid = valid_r;
    assign xfer_cnt  = cnt_r;

endmodule

// File: tb/tb_dmux_stream.sv
// Directed self-checking bench for dmux_stream (default parameters).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_dmux_stream;

    localparam int WIDTH = 16;
    localparam int SEL_W = 3;
    localparam int NWAY  = 8;

    logic                    clk;
    logic                    reset;
    logic [WIDTH-1:0]        in_data;
    logic [SEL_W-1:0]        in_sel;
    logic                    in_bcast;
    logic                    in_valid;
    logic                    in_ready;
    logic [NWAY*WIDTH-1:0]   out_data;
    logic [NWAY-1:0]         out_valid;
    logic [NWAY-1:0]         out_ready;
    logic [15:0]             xfer_cnt;

    int n_checks;
    int n_fail;

    dmux_stream #(.WIDTH(WIDTH), .SEL_W(SEL_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_bcast  (in_bcast),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .xfer_cnt  (xfer_cnt)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Directed stimulus and checks.
    initial begin
        n_checks  = 0;
        n_fail    = 0;
        reset     = 1'b1;
        in_data   = 16'h0000;
        in_sel    = 3'd0;
        in_bcast  = 1'b0;
        in_valid  = 1'b0;
        out_ready = 8'h00;

        // Reset state
        @(negedge clk);
        chk("rst_valid", out_valid, 8'h00);
        chk("rst_data", out_data, 128'h0);
        chk("rst_cnt", xfer_cnt, 16'h0000);
        for (int s = 0; s < NWAY; s++) begin
            in_sel = s[2:0];
            #1;
            chk("rst_ready", in_ready, 1'b1);
        end
        reset = 1'b0;
        in_sel = 3'd6;
        @(negedge clk);
        chk("post_rst_ready", in_ready, 1'b1);

        // Unicast to channel 5
        in_sel = 3'd5; in_data = 16'hBEEF; in_valid = 1'b1;
        #1 chk("uni_ready", in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("uni_valid", out_valid, 8'b0010_0000);
        chk("uni_data5", out_data[5*WIDTH +: WIDTH], 16'hBEEF);
        chk("uni_cnt", xfer_cnt, 16'd1);
        chk("uni_data0", out_data[0 +: WIDTH], 16'h0000);
        out_ready = 8'h20;
        @(negedge clk);
        out_ready = 8'h00;
        chk("uni_drained", out_valid, 8'h00);
        chk("uni_hold5", out_data[5*WIDTH +: WIDTH], 16'hBEEF);

        // Backpressure on channel 2, unicast to channel 3 still flows
        in_sel = 3'd2; in_data = 16'h2222; in_valid = 1'b1;
        @(negedge clk);
        in_data = 16'h5555;
        #1 chk("bp_ready2", in_ready, 1'b0);
        @(negedge clk);
        chk("bp_valid", out_valid, 8'h04);
        chk("bp_hold2", out_data[2*WIDTH +: WIDTH], 16'h2222);
        in_sel = 3'd3; in_data = 16'h3333;
        #1 chk("bp_ready3", in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_valid23", out_valid, 8'h0C);
        chk("bp_data3", out_data[3*WIDTH +: WIDTH], 16'h3333);
        chk("bp_cnt", xfer_cnt, 16'd3);
        out_ready = 8'hFF;
        @(negedge clk);
        out_ready = 8'h00;
        chk("bp_drained", out_valid, 8'h00);

        // Drain and refill: 4 back-to-back words to channel 1
        out_ready = 8'h02;
        in_sel = 3'd1; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 16'hA000 + 16'(i);
            #1 chk("dr_ready", in_ready, 1'b1);
            if (i > 0) begin
                chk("dr_valid", out_valid, 8'h02);
                chk("dr_data", out_data[1*WIDTH +: WIDTH], 16'hA000 + 16'(i - 1));
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("dr_last_valid", out_valid, 8'h02);
        chk("dr_last_data", out_data[1*WIDTH +: WIDTH], 16'hA003);
        @(negedge clk);
        chk("dr_empty", out_valid, 8'h00);
        chk("dr_cnt", xfer_cnt, 16'd7);
        out_ready = 8'h00;

        // Broadcast with all channels empty
        in_bcast = 1'b1; in_data = 16'h1234; in_valid = 1'b1;
        #1 chk("bc_ready", in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bc_valid", out_valid, 8'hFF);
        for (int k = 0; k < NWAY; k++) begin
            chk("bc_data", out_data[k*WIDTH +: WIDTH], 16'h1234);
        end
        chk("bc_cnt", xfer_cnt, 16'd8);
        out_ready = 8'h7F;
        @(negedge clk);
        out_ready = 8'h00;
        chk("bc_stall7", out_valid, 8'h80);

        // Channel 7 stalled: unicast elsewhere still ready, broadcast blocked
        in_bcast = 1'b0; in_sel = 3'd0;
        #1 chk("bc_uni_ok", in_ready, 1'b1);
        in_sel = 3'd7;
        #1 chk("bc_uni_7", in_ready, 1'b0);
        in_bcast = 1'b1; in_data = 16'h5678; in_valid = 1'b1;
        #1 chk("bc_blocked", in_ready, 1'b0);
        @(negedge clk);
        chk("bc_blk_valid", out_valid, 8'h80);
        chk("bc_blk_cnt", xfer_cnt, 16'd8);
        chk("bc_blk_data7", out_data[7*WIDTH +: WIDTH], 16'h1234);
        out_ready = 8'h80;
        #1 chk("bc_release", in_ready, 1'b1);
        @(negedge clk);
        out_ready = 8'h00; in_valid = 1'b0; in_bcast = 1'b0;
        chk("bc2_valid", out_valid, 8'hFF);
        chk("bc2_data7", out_data[7*WIDTH +: WIDTH], 16'h5678);
        chk("bc2_data0", out_data[0 +: WIDTH], 16'h5678);
        chk("bc2_cnt", xfer_cnt, 16'd9);

        // Reset mid-stream with channels 0 and 4 loaded
        out_ready = 8'hEE;
        @(negedge clk);
        out_ready = 8'h00;
        chk("mr_pre_valid", out_valid, 8'h11);
        chk("mr_pre_cnt", xfer_cnt, 16'd9);
        #2 reset = 1'b1;
        #1;
        chk("mr_valid", out_valid, 8'h00);
        chk("mr_data", out_data, 128'h0);
        chk("mr_cnt", xfer_cnt, 16'd0);
        in_sel = 3'd4;
        chk("mr_ready", in_ready, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        out_ready = 8'hFF;
        @(negedge clk);
        chk("mr_after_valid", out_valid, 8'h00);
        chk("mr_after_cnt", xfer_cnt, 16'd0);

        // Counter wrap: 65535 transfers, then one more
        in_bcast = 1'b0; in_sel = 3'd0; in_data = 16'hC0DE; in_valid = 1'b1;
        repeat (65535) @(negedge clk);
        chk("wrap_ffff", xfer_cnt, 16'hFFFF);
        @(negedge clk);
        in_valid = 1'b0;
        chk("wrap_zero", xfer_cnt, 16'h0000);
        @(negedge clk);
        chk("idle_cnt", xfer_cnt, 16'h0000);
        chk("idle_valid", out_valid, 8'h00);
        chk("idle_hold0", out_data[0 +: WIDTH], 16'hC0DE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
